// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: start control, instruction-memory read port, decode handshake and status.
interface fetch_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 24
);
    logic          start;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          branch_taken;
    logic [AW-1:0] branch_imm;
    logic [AW-1:0] pc;
    logic          halted;
    logic [15:0]   fetch_count;

    modport master (
        input  start, imem_rdata, instr_ready, branch_taken, branch_imm,
        output imem_en, imem_addr, instr, instr_valid, pc, halted, fetch_count
    );

    modport slave (
        output start, imem_rdata, instr_ready, branch_taken, branch_imm,
        input  imem_en, imem_addr, instr, instr_valid, pc, halted, fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and fixed-latency fetch controller; ISSUE to instr_valid takes MEM_LAT+1 cycles.
// Backpressure: the captured instr is held in HOLD until instr_ready, and no new read is issued meanwhile.
module fetch_sequencer #(
    parameter int            AW       = 8,
    parameter int            DW       = 24,
    parameter int            MEM_LAT  = 1,
    parameter logic [3:0]    HALT_OP  = 4'hF,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    lat_q, lat_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [15:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                lat_d   = 4'(MEM_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd1) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_HOLD;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (instr_q[DW-1 -: 4] == HALT_OP) begin
                        state_d = S_HALT;
                    end else begin
                        // Modulo-2^AW add: signed and unsigned offsets wrap identically.
                        pc_d    = bus.branch_taken ? (pc_q + bus.branch_imm) : (pc_q + AW'(1));
                        state_d = S_ISSUE;
                    end
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    pc_d    = pc_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address register loads on ISSUE entry so imem_addr is a clean flop output.
        if (state_d == S_ISSUE) addr_d = pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            lat_q   <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_en     = (state_q == S_ISSUE);
    assign bus.imem_addr   = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_HOLD);
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Two fetch_sequencer instances (memory latency 1 and 3) share stimulus; each is checked every
// cycle against a timestamp-based model, with directed literal checks pinning key behaviour.
module tb_fetch_sequencer;
    localparam int AW = 8;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, instr_ready, branch_taken;
    logic [AW-1:0] branch_imm;
    logic [DW-1:0] rdata0, rdata1;

    fetch_sequencer_if #(.AW(AW), .DW(DW)) if0 ();
    fetch_sequencer_if #(.AW(AW), .DW(DW)) if1 ();

    assign if0.start = start;        assign if1.start = start;
    assign if0.instr_ready = instr_ready;   assign if1.instr_ready = instr_ready;
    assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;
    assign if0.branch_imm = branch_imm;     assign if1.branch_imm = branch_imm;
    assign if0.imem_rdata = rdata0;  assign if1.imem_rdata = rdata1;

    fetch_sequencer #(.AW(AW), .DW(DW), .MEM_LAT(1), .HALT_OP(4'hF), .RESET_PC(8'h00))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    fetch_sequencer #(.AW(AW), .DW(DW), .MEM_LAT(3), .HALT_OP(4'hF), .RESET_PC(8'h00))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    logic [DW-1:0] mem [256];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference model: each instance is either running (with the cycle of its last issue),
    // halted, or idle; everything else follows from timestamps and the memory contents.
    bit            m_run  [2];
    bit            m_halt [2];
    int            m_tiss [2];
    logic [7:0]    m_pc   [2];
    logic [7:0]    m_addr [2];
    logic [15:0]   m_cnt  [2];
    logic [23:0]   m_instr[2];

    // Memory model: reads sampled in cycle c return data during cycle c+latency.
    bit            pend_v [2][16];
    logic [7:0]    pend_a [2][16];

    logic          o_en [2], o_val [2], o_halt [2];
    logic [7:0]    o_pc [2], o_addr [2];
    logic [15:0]   o_cnt [2];
    logic [23:0]   o_instr [2];
    int            lk, slot, ps;
    logic          e_en, e_val;
    logic [DW-1:0] rd;

    always @(negedge clk) begin
        o_en[0] = if0.imem_en;   o_val[0] = if0.instr_valid; o_halt[0] = if0.halted;
        o_pc[0] = if0.pc;        o_addr[0] = if0.imem_addr;  o_cnt[0] = if0.fetch_count;
        o_instr[0] = if0.instr;
        o_en[1] = if1.imem_en;   o_val[1] = if1.instr_valid; o_halt[1] = if1.halted;
        o_pc[1] = if1.pc;        o_addr[1] = if1.imem_addr;  o_cnt[1] = if1.fetch_count;
        o_instr[1] = if1.instr;

        for (int k = 0; k < 2; k++) begin
            lk = (k == 0) ? 1 : 3;
            if (reset) begin
                m_run[k] = 0; m_halt[k] = 0; m_tiss[k] = -100;
                m_pc[k] = 8'h00; m_addr[k] = 8'h00; m_cnt[k] = 16'h0; m_instr[k] = 24'h0;
            end
            e_en  = m_run[k] && (cyc == m_tiss[k]);
            e_val = m_run[k] && (cyc >= m_tiss[k] + lk + 1);
            chk("imem_en",     k, 32'(o_en[k]),   32'(e_en));
            chk("instr_valid", k, 32'(o_val[k]),  32'(e_val));
            chk("halted",      k, 32'(o_halt[k]), 32'(m_halt[k]));
            chk("pc",          k, 32'(o_pc[k]),   32'(m_pc[k]));
            chk("imem_addr",   k, 32'(o_addr[k]), 32'(m_addr[k]));
            chk("fetch_count", k, 32'(o_cnt[k]),  32'(m_cnt[k]));
            chk("instr",       k, 32'(o_instr[k]), 32'(m_instr[k]));

            if (!reset) begin
                if (m_run[k] && cyc == m_tiss[k] + lk) m_instr[k] = mem[m_pc[k]];
                if (!m_run[k]) begin
                    if (start) begin
                        if (m_halt[k]) m_pc[k] = m_pc[k] + 8'd1;
                        m_halt[k] = 0; m_run[k] = 1; m_tiss[k] = cyc + 1; m_addr[k] = m_pc[k];
                    end
                end else if (e_val && instr_ready) begin
                    if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
                    if (m_instr[k][23:20] == 4'hF) begin
                        m_run[k] = 0; m_halt[k] = 1;
                    end else begin
                        m_pc[k] = m_pc[k] + (branch_taken ? branch_imm : 8'd1);
                        m_tiss[k] = cyc + 1; m_addr[k] = m_pc[k];
                    end
                end
            end

            slot = cyc % 16;
            pend_v[k][slot] = o_en[k];
            pend_a[k][slot] = o_addr[k];
            ps = (cyc + 16 - lk) % 16;
            if (cyc >= lk && pend_v[k][ps]) rd = mem[pend_a[k][ps]];
            else rd = DW'($urandom);
            if (k == 0) rdata0 = rd; else rdata1 = rd;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int k);
        int b = 0;
        while (((k == 0) ? if0.instr_valid : if1.instr_valid) !== 1'b1 && b < 20) begin
            step();
            b++;
        end
        chk("wait_valid", k, 32'((k == 0) ? if0.instr_valid : if1.instr_valid), 32'd1);
    endtask

    task automatic accept0(input logic br, input logic [7:0] imm);
        wait_valid(0);
        instr_ready = 1'b1; branch_taken = br; branch_imm = imm;
        step();
        instr_ready = 1'b0; branch_taken = 1'b0; branch_imm = 8'h00;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; branch_imm = 8'h00;
        rdata0 = '0; rdata1 = '0;
        for (int a = 0; a < 256; a++) mem[a] = {8'h00, 16'(a + 1000)};
        mem[64] = {4'hF, 4'h0, 16'(64 + 1000)};
        repeat (3) step();
        chk("rst_pc", 0, 32'(if0.pc), 32'h0);
        chk("rst_en", 0, 32'(if0.imem_en), 32'h0);
        chk("rst_cnt", 0, 32'(if0.fetch_count), 32'h0);

        reset = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        chk("t1_en", 0, 32'(if0.imem_en), 32'h1);
        chk("t1_addr", 0, 32'(if0.imem_addr), 32'h0);
        step();
        chk("t1_wait_valid", 0, 32'(if0.instr_valid), 32'h0);
        step();
        chk("t1_valid", 0, 32'(if0.instr_valid), 32'h1);
        chk("t1_instr", 0, 32'(if0.instr), 32'd1000);

        repeat (5) step();
        chk("t2_instr", 0, 32'(if0.instr), 32'd1000);
        chk("t2_pc", 0, 32'(if0.pc), 32'h0);
        chk("t2_cnt0", 0, 32'(if0.fetch_count), 32'h0);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t2_cnt1", 0, 32'(if0.fetch_count), 32'h1);
        chk("t2_valid_drop", 0, 32'(if0.instr_valid), 32'h0);

        accept0(1'b0, 8'h00);
        accept0(1'b0, 8'h00);
        chk("t1_pc3", 0, 32'(if0.pc), 32'h3);
        branch_taken = 1'b1; branch_imm = 8'h55;
        step(); step();
        branch_taken = 1'b0; branch_imm = 8'h00;
        accept0(1'b1, 8'h05);
        chk("t3_branch", 0, 32'(if0.pc), 32'h08);
        chk("t3_addr", 0, 32'(if0.imem_addr), 32'h08);

        accept0(1'b1, 8'hF7);
        chk("t4_pcff", 0, 32'(if0.pc), 32'hFF);
        accept0(1'b0, 8'h00);
        chk("t4_wrap", 0, 32'(if0.pc), 32'h00);
        accept0(1'b0, 8'h00);
        accept0(1'b0, 8'h00);
        accept0(1'b1, 8'hFE);
        chk("t4_neg", 0, 32'(if0.pc), 32'h00);

        accept0(1'b1, 8'h40);
        accept0(1'b0, 8'h00);
        chk("t5_halted", 0, 32'(if0.halted), 32'h1);
        chk("t5_valid", 0, 32'(if0.instr_valid), 32'h0);
        repeat (10) step();
        chk("t5_pc", 0, 32'(if0.pc), 32'h40);
        start = 1'b1; step(); start = 1'b0;
        chk("t5_restart_en", 0, 32'(if0.imem_en), 32'h1);
        chk("t5_restart_addr", 0, 32'(if0.imem_addr), 32'h41);
        accept0(1'b0, 8'h00);

        reset = 1'b1; step(); reset = 1'b0; step();
        start = 1'b1; step(); start = 1'b0;
        wait_valid(1);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("t6_cnt_pre", 1, 32'(if1.fetch_count), 32'h1);
        chk("t6_instr_pre", 1, 32'(if1.instr), 32'd1000);
        step(); step();
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_pc", 1, 32'(if1.pc), 32'h0);
        chk("t6_rst_instr", 1, 32'(if1.instr), 32'h0);
        chk("t6_rst_cnt", 1, 32'(if1.fetch_count), 32'h0);
        chk("t6_rst_addr", 1, 32'(if1.imem_addr), 32'h0);
        step(); reset = 1'b0;
        repeat (6) step();
        chk("t6_late_instr", 1, 32'(if1.instr), 32'h0);
        chk("t6_late_valid", 1, 32'(if1.instr_valid), 32'h0);

        reset = 1'b1;
        for (int a = 0; a < 256; a++)
            mem[a] = {(($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14))),
                      4'($urandom), 16'(a + 1000)};
        step(); reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            start        = ($urandom_range(0, 9) == 0);
            instr_ready  = ($urandom_range(0, 2) != 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_imm   = 8'($urandom);
            reset        = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
